// File: rtl/bind_op_scheduler.sv
// Round-robin front end, command FIFO and single-issue FSM sharing one BindKernelMapper between clients.
// k_valid rises two edges after an accept into an empty FIFO; a full FIFO drops every req_ready (no bypass).
module bind_op_scheduler #(
    parameter int HV_ADDRESS_WIDTH       = 5,
    parameter int MAX_HYPERVECTOR_LENGTH = 4,
    parameter int NUM_REQUESTERS         = 2,
    parameter int FIFO_DEPTH             = 4,
    parameter int TIMEOUT_CYCLES         = 64,
    localparam int AW   = HV_ADDRESS_WIDTH,
    localparam int N    = NUM_REQUESTERS,
    localparam int ID_W = $clog2(NUM_REQUESTERS),
    localparam int CW   = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [N-1:0]      i_req_valid,
    output logic [N-1:0]      o_req_ready,
    input  logic [N*AW-1:0]   i_req_vec_length,
    input  logic [N*AW-1:0]   i_req_hva,
    input  logic [N*AW-1:0]   i_req_hvb,
    input  logic [N*AW-1:0]   i_req_hvc,
    output logic              o_k_valid,
    output logic [AW-1:0]     o_k_vec_length,
    output logic [AW-1:0]     o_k_hva,
    output logic [AW-1:0]     o_k_hvb,
    output logic [AW-1:0]     o_k_hvc,
    input  logic              i_k_done,
    output logic              o_cmp_valid,
    output logic [ID_W-1:0]   o_cmp_id,
    output logic              o_cmp_err,
    output logic              o_busy,
    output logic [CW-1:0]     o_fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [AW-1:0]   len;
        logic [AW-1:0]   hva;
        logic [AW-1:0]   hvb;
        logic [AW-1:0]   hvc;
    } cmd_t;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ISSUE, S_RELEASE} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    cmd_t            r_mem [FIFO_DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [ID_W-1:0] r_rr_ptr;
    logic [TW-1:0]   r_timer;
    logic [AW-1:0]   r_k_len;
    logic [AW-1:0]   r_k_hva;
    logic [AW-1:0]   r_k_hvb;
    logic [AW-1:0]   r_k_hvc;
    logic [ID_W-1:0] r_cmp_id;
    logic            r_cmp_valid;
    logic            r_cmp_err;

    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic [N-1:0]    w_grant;
    logic [ID_W-1:0] w_gnt_idx;
    cmd_t            w_push_cmd;
    cmd_t            w_head;
    logic            w_len_ok;
    logic            w_timer_last;

    assign w_full       = (r_count == CW'(FIFO_DEPTH));
    assign w_pop        = (r_state == S_IDLE) && (r_count != '0);
    assign w_head       = r_mem[r_rd_ptr];
    assign w_len_ok     = (r_k_len != '0) && (r_k_len <= AW'(MAX_HYPERVECTOR_LENGTH));
    assign w_timer_last = (r_timer == TW'(TIMEOUT_CYCLES - 1));

    // Grant search starts at the round-robin pointer; gated by reset so every output reads 0 while it is held.
    always_comb begin
        w_grant   = '0;
        w_gnt_idx = '0;
        w_push    = 1'b0;
        if (!w_full && !i_reset) begin
            for (int k = 0; k < N; k++) begin
                if (!w_push && i_req_valid[(int'(r_rr_ptr) + k) % N]) begin
                    w_push    = 1'b1;
                    w_gnt_idx = ID_W'((int'(r_rr_ptr) + k) % N);
                    w_grant[(int'(r_rr_ptr) + k) % N] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_push_cmd.id  = w_gnt_idx;
        w_push_cmd.len = i_req_vec_length[int'(w_gnt_idx)*AW +: AW];
        w_push_cmd.hva = i_req_hva[int'(w_gnt_idx)*AW +: AW];
        w_push_cmd.hvb = i_req_hvb[int'(w_gnt_idx)*AW +: AW];
        w_push_cmd.hvc = i_req_hvc[int'(w_gnt_idx)*AW +: AW];
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_cmd;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rr_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_rr_ptr <= (int'(w_gnt_idx) == N - 1) ? '0 : w_gnt_idx + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // State register plus the registers that travel with it (command latch, timer, completion pulse).
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_k_len     <= '0;
            r_k_hva     <= '0;
            r_k_hvb     <= '0;
            r_k_hvc     <= '0;
            r_cmp_id    <= '0;
            r_cmp_valid <= 1'b0;
            r_cmp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmp_valid <= 1'b0;
            r_cmp_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_k_len  <= w_head.len;
                        r_k_hva  <= w_head.hva;
                        r_k_hvb  <= w_head.hvb;
                        r_k_hvc  <= w_head.hvc;
                        r_cmp_id <= w_head.id;
                    end
                end
                S_LOAD: begin
                    r_timer <= '0;
                    if (!w_len_ok) begin
                        r_cmp_valid <= 1'b1;
                        r_cmp_err   <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (i_k_done || w_timer_last) begin
                        r_timer     <= '0;
                        r_cmp_valid <= 1'b1;
                        r_cmp_err   <= !i_k_done;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_RELEASE: begin
                    r_timer <= r_timer + 1'b1;
                end
                default: begin
                    r_timer <= '0;
                end
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_pop) w_state_nxt = S_LOAD;
            S_LOAD:    w_state_nxt = w_len_ok ? S_ISSUE : S_IDLE;
            S_ISSUE:   if (i_k_done || w_timer_last) w_state_nxt = S_RELEASE;
            S_RELEASE: if (!i_k_done || w_timer_last) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_req_ready    = w_grant;
        o_k_valid      = (r_state == S_ISSUE);
        o_k_vec_length = r_k_len;
        o_k_hva        = r_k_hva;
        o_k_hvb        = r_k_hvb;
        o_k_hvc        = r_k_hvc;
        o_cmp_valid    = r_cmp_valid;
        o_cmp_id       = r_cmp_id;
        o_cmp_err      = r_cmp_err;
        o_fifo_count   = r_count;
        o_busy         = (r_count != '0) || (r_state != S_IDLE) || r_cmp_valid;
    end

endmodule

// File: tb/tb_bind_op_scheduler.sv
// Directed bench for bind_op_scheduler: single command, bad lengths, round-robin, full FIFO with timeout, async reset.
module tb_bind_op_scheduler;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [2*AW-1:0] req_len, req_hva, req_hvb, req_hvc;
    logic          k_valid;
    logic [AW-1:0] k_len, k_hva, k_hvb, k_hvc;
    logic          k_done;
    logic          cmp_valid;
    logic          cmp_id;
    logic          cmp_err;
    logic          busy;
    logic [2:0]    fifo_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bind_op_scheduler #(
        .HV_ADDRESS_WIDTH(5), .MAX_HYPERVECTOR_LENGTH(4), .NUM_REQUESTERS(2),
        .FIFO_DEPTH(4), .TIMEOUT_CYCLES(64)
    ) dut (
        .i_clk(clk), .i_reset(reset),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_vec_length(req_len), .i_req_hva(req_hva), .i_req_hvb(req_hvb), .i_req_hvc(req_hvc),
        .o_k_valid(k_valid), .o_k_vec_length(k_len), .o_k_hva(k_hva), .o_k_hvb(k_hvb), .o_k_hvc(k_hvc),
        .i_k_done(k_done),
        .o_cmp_valid(cmp_valid), .o_cmp_id(cmp_id), .o_cmp_err(cmp_err),
        .o_busy(busy), .o_fifo_count(fifo_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int c, input int len, input int hva, input int hvb, input int hvc);
        req_len[c*AW +: AW] = len[AW-1:0];
        req_hva[c*AW +: AW] = hva[AW-1:0];
        req_hvb[c*AW +: AW] = hvb[AW-1:0];
        req_hvc[c*AW +: AW] = hvc[AW-1:0];
    endtask

    initial begin
        int sent [2];
        int exp_id [$];
        int exp_hvc [$];
        int done_cnt;
        int kv;
        int nxt_grant;
        int g;
        int cnt;
        bit flag;

        reset = 1'b1; req_valid = '0; k_done = 1'b0;
        req_len = '0; req_hva = '0; req_hvb = '0; req_hvc = '0;
        tick(); tick();
        chk("rst_kvalid", k_valid, 0);
        chk("rst_count", fifo_count, 0);
        reset = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_cmp", cmp_valid, 0);

        // Single command from client 0
        set_cmd(0, 4, 0, 4, 8);
        req_valid = 2'b01;
        #1;
        chk("s_ready", req_ready, 2'b01);
        tick();
        req_valid = '0;
        chk("s_count1", fifo_count, 1);
        chk("s_kv_e0", k_valid, 0);
        chk("s_busy", busy, 1);
        tick();
        chk("s_kv_e1", k_valid, 0);
        chk("s_count0", fifo_count, 0);
        tick();
        chk("s_kv_e2", k_valid, 1);
        chk("s_len", k_len, 4);
        chk("s_hva", k_hva, 0);
        chk("s_hvb", k_hvb, 4);
        chk("s_hvc", k_hvc, 8);
        repeat (5) tick();
        chk("s_kv_hold", k_valid, 1);
        chk("s_hvc_hold", k_hvc, 8);
        k_done = 1'b1;
        tick();
        k_done = 1'b0;
        chk("s_kv_drop", k_valid, 0);
        chk("s_cmp", cmp_valid, 1);
        chk("s_cmp_id", cmp_id, 0);
        chk("s_cmp_err", cmp_err, 0);
        tick();
        chk("s_cmp_pulse", cmp_valid, 0);
        chk("s_idle_busy", busy, 0);

        // Bad lengths from client 1: 0 then 5
        set_cmd(1, 0, 1, 2, 3);
        req_valid = 2'b10;
        #1;
        chk("b0_ready", req_ready, 2'b10);
        tick();
        req_valid = '0;
        tick();
        chk("b0_cmp_early", cmp_valid, 0);
        tick();
        chk("b0_cmp", cmp_valid, 1);
        chk("b0_err", cmp_err, 1);
        chk("b0_id", cmp_id, 1);
        chk("b0_kv", k_valid, 0);
        set_cmd(1, 5, 1, 2, 3);
        req_valid = 2'b10;
        #1;
        chk("b5_ready", req_ready, 2'b10);
        tick();
        req_valid = '0;
        tick();
        chk("b5_kv", k_valid, 0);
        tick();
        chk("b5_cmp", cmp_valid, 1);
        chk("b5_err", cmp_err, 1);
        chk("b5_id", cmp_id, 1);
        chk("b5_kv2", k_valid, 0);
        tick();
        chk("b_busy", busy, 0);

        // Round-robin: both clients keep four commands each pending
        sent[0] = 0; sent[1] = 0; done_cnt = 0; kv = 0; nxt_grant = 0;
        for (int cyc = 0; cyc < 400 && done_cnt < 8; cyc++) begin
            kv = k_valid ? kv + 1 : 0;
            if (cmp_valid) begin
                chk("rr_cmp_id", cmp_id, exp_id.pop_front());
                chk("rr_cmp_hvc", k_hvc, exp_hvc.pop_front());
                chk("rr_cmp_err", cmp_err, 0);
                done_cnt++;
            end
            for (int c = 0; c < 2; c++) begin
                req_valid[c] = (sent[c] < 4);
                set_cmd(c, 2, sent[c], c, c*8 + sent[c]);
            end
            k_done = k_valid && (kv >= 2);
            #1;
            if (req_ready != '0) begin
                chk("rr_grant", req_ready, (nxt_grant == 0) ? 2'b01 : 2'b10);
                g = req_ready[1] ? 1 : 0;
                exp_id.push_back(g);
                exp_hvc.push_back(g*8 + sent[g]);
                sent[g]++;
                nxt_grant = 1 - g;
            end
            tick();
        end
        chk("rr_done", done_cnt, 8);
        req_valid = '0; k_done = 1'b0;
        tick(); tick();
        chk("rr_busy", busy, 0);

        // Full FIFO with a stalled mapper, then timeout of the head command
        for (int n = 0; n < 5; n++) begin
            set_cmd(0, 1 + n % 4, n, n, 16 + n);
            req_valid = 2'b01;
            #1;
            chk("ff_ready", req_ready, 2'b01);
            tick();
        end
        set_cmd(0, 3, 5, 5, 21);
        #1;
        chk("ff_count", fifo_count, 4);
        chk("ff_block", req_ready, 2'b00);
        chk("ff_kv", k_valid, 1);
        cnt = 3; flag = 1'b0;
        for (int i = 0; i < 200 && k_valid; i++) begin
            if (req_ready != '0 || fifo_count != 3'd4) flag = 1'b1;
            tick();
            if (k_valid) cnt++;
        end
        chk("to_hold", flag, 0);
        chk("to_cycles", cnt, 64);
        chk("to_cmp", cmp_valid, 1);
        chk("to_err", cmp_err, 1);
        chk("to_id", cmp_id, 0);
        chk("to_hvc", k_hvc, 16);
        tick();
        chk("to_pulse", cmp_valid, 0);
        chk("to_full", req_ready, 2'b00);
        tick();
        chk("to_pop_count", fifo_count, 3);
        chk("to_pop_ready", req_ready, 2'b01);
        tick();
        chk("to_next_kv", k_valid, 1);
        chk("to_next_hvc", k_hvc, 17);
        chk("to_next_len", k_len, 2);
        chk("to_refill", fifo_count, 4);

        // Asynchronous reset in ISSUE with commands queued
        #1;
        reset = 1'b1;
        #1;
        chk("ar_kv", k_valid, 0);
        chk("ar_count", fifo_count, 0);
        chk("ar_busy", busy, 0);
        chk("ar_ready", req_ready, 2'b00);
        chk("ar_len", k_len, 0);
        chk("ar_hvc", k_hvc, 0);
        chk("ar_cmp", {cmp_valid, cmp_id, cmp_err}, 0);
        req_valid = '0;
        tick();
        reset = 1'b0;
        flag = 1'b0;
        repeat (10) begin
            tick();
            if (cmp_valid || k_valid || fifo_count != 0) flag = 1'b1;
        end
        chk("ar_quiet", flag, 0);
        chk("ar_busy_after", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
